// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, oversampling and sample-point
// constants, parity selectors and a 2-of-3 vote helper (used by rx and tx).
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_HOLD   = 3'd5
  } uart_state_t;

  localparam int unsigned OVS       = 16;
  localparam int unsigned TICK_W    = 5;
  localparam int unsigned START_MID = 7;
  localparam int unsigned BIT_END   = OVS - 1;

  localparam int unsigned PAR_EVEN  = 0;
  localparam int unsigned PAR_ODD   = 1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs; resets to 1 (idle line).
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_parity.sv
// UART receiver with parity check: 16x oversampled, LSB-first, one parity bit.
// Define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote of the last three ticks.
module uart_rx_parity
  import uart_pkg::*;
#(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned PARITY_ODD = PAR_EVEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            parity_err,
  output logic            frame_err
);

  localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  logic              rx_s;
  uart_state_t       state_reg, state_next;
  logic [TICK_W-1:0] s_reg, s_next, s_end_c;
  logic [NW-1:0]     n_reg, n_next;
  logic [DBIT-1:0]   b_reg, b_next, dout_next;
  logic              p_reg, p_next;
  logic              perr_next, ferr_next, done_next;
  logic              bit_val_c;

  uart_sync2 u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // Tick count at which the current state takes its decision
  always_comb begin
    case (state_reg)
      ST_START: s_end_c = TICK_W'(START_MID);
      ST_STOP:  s_end_c = TICK_W'(SB_TICK - 1);
      default:  s_end_c = TICK_W'(BIT_END);
    endcase
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] m_reg, m_next;

  // Capture the two ticks preceding the decision point
  always_comb begin
    m_next = m_reg;
    if (s_tick) begin
      if (s_reg == s_end_c - TICK_W'(2)) m_next[0] = rx_s;
      if (s_reg == s_end_c - TICK_W'(1)) m_next[1] = rx_s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) m_reg <= 2'b11;
    else        m_reg <= m_next;
  end

  assign bit_val_c = maj3(m_reg[0], m_reg[1], rx_s);
`else
  assign bit_val_c = rx_s;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      s_reg        <= '0;
      n_reg        <= '0;
      b_reg        <= '0;
      p_reg        <= 1'b0;
      dout         <= '0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      rx_done_tick <= 1'b0;
    end else begin
      state_reg    <= state_next;
      s_reg        <= s_next;
      n_reg        <= n_next;
      b_reg        <= b_next;
      p_reg        <= p_next;
      dout         <= dout_next;
      parity_err   <= perr_next;
      frame_err    <= ferr_next;
      rx_done_tick <= done_next;
    end
  end

  // Next-state and datapath; everything except leaving IDLE waits for s_tick
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    p_next     = p_reg;
    dout_next  = dout;
    perr_next  = parity_err;
    ferr_next  = frame_err;
    done_next  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (!rx_s) begin
          state_next = ST_START;
          s_next     = '0;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_reg == s_end_c) begin
            s_next = '0;
            if (!bit_val_c) begin
              state_next = ST_DATA;
              n_next     = '0;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            s_next = s_reg + TICK_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_reg == s_end_c) begin
            s_next = '0;
            b_next = {bit_val_c, b_reg[DBIT-1:1]};
            if (n_reg == NW'(DBIT - 1)) state_next = ST_PARITY;
            else                        n_next     = n_reg + NW'(1);
          end else begin
            s_next = s_reg + TICK_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (s_tick) begin
          if (s_reg == s_end_c) begin
            s_next     = '0;
            p_next     = bit_val_c;
            state_next = ST_STOP;
          end else begin
            s_next = s_reg + TICK_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (s_reg == s_end_c) begin
            s_next     = '0;
            dout_next  = b_reg;
            perr_next  = (^b_reg) ^ p_reg ^ 1'(PARITY_ODD);
            ferr_next  = ~bit_val_c;
            done_next  = 1'b1;
            state_next = bit_val_c ? ST_IDLE : ST_HOLD;
          end else begin
            s_next = s_reg + TICK_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (s_tick && rx_s) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_parity.sv
// Scoreboard bench for uart_rx_parity: an even- and an odd-parity receiver share one rx line.
module tb_uart_rx_parity;

  localparam int unsigned TICK_DIV  = 5;
  localparam int unsigned CYC_LIMIT = 60000;

  typedef struct {
    logic [7:0] d;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       rx;
  logic       rx_done_tick, parity_err, frame_err;
  logic [7:0] dout;
  logic       rx_done_odd, parity_err_odd, frame_err_odd;
  logic [7:0] dout_odd;

  logic [2:0] div_cnt;

  exp_t exp_q[$];
  exp_t exp_odd_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int rst_chk_req = 0;
  int rst_chk_done = 0;
  bit end_req = 1'b0;

  uart_rx_parity #(.DBIT(8), .SB_TICK(16), .PARITY_ODD(0)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx           (rx),
    .rx_done_tick (rx_done_tick),
    .dout         (dout),
    .parity_err   (parity_err),
    .frame_err    (frame_err)
  );

  uart_rx_parity #(.DBIT(8), .SB_TICK(16), .PARITY_ODD(1)) u_dut_odd (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx           (rx),
    .rx_done_tick (rx_done_odd),
    .dout         (dout_odd),
    .parity_err   (parity_err_odd),
    .frame_err    (frame_err_odd)
  );

  always #10 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      s_tick  <= 1'b0;
    end else if (div_cnt == 3'(TICK_DIV - 1)) begin
      div_cnt <= '0;
      s_tick  <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 3'd1;
      s_tick  <= 1'b0;
    end
  end

  // Returns at the falling edge just after the DUT has consumed one s_tick
  task automatic next_tick();
    @(negedge clk);
    while (s_tick !== 1'b1) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int k);
    repeat (k) next_tick();
  endtask

  task automatic expect_word(input logic [7:0] d, input logic perr, input logic ferr);
    exp_t e;
    e.d = d; e.perr = perr; e.ferr = ferr;
    exp_q.push_back(e);
    e.perr = ~perr;
    exp_odd_q.push_back(e);
  endtask

  // glitch_bit: one-tick high pulse at that data bit's sample tick; abort_bit: reset mid-bit
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop,
                            input int glitch_bit, input int abort_bit);
    bit aborted = 1'b0;
    next_tick();
    rx = 1'b0;
    ticks(16);
    for (int i = 0; i < 8 && !aborted; i++) begin
      rx = d[i];
      if (i == abort_bit) begin
        ticks(8);
        @(posedge clk);
        #1;
        reset = 1'b0;
        rst_chk_req++;
        rx = 1'b1;
        aborted = 1'b1;
      end else if (i == glitch_bit) begin
        ticks(7);
        rx = 1'b1;
        ticks(1);
        rx = d[i];
        ticks(8);
      end else begin
        ticks(16);
      end
    end
    if (!aborted) begin
      rx = p;
      ticks(16);
      rx = stop;
      ticks(16);
      if (stop) ticks(4);
    end
  endtask

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, want);
    end
  endtask

  // Monitor: reset-value checks, strobe scoreboard, end-of-run and watchdog
  initial begin
    exp_t e;
    int cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset && rst_chk_done != rst_chk_req) begin
        chk("rst_dout",       dout,              8'h00);
        chk("rst_parity_err", 8'(parity_err),    8'h00);
        chk("rst_frame_err",  8'(frame_err),     8'h00);
        chk("rst_done",       8'(rx_done_tick),  8'h00);
        chk("rst_dout_odd",   dout_odd,          8'h00);
        chk("rst_perr_odd",   8'(parity_err_odd), 8'h00);
        chk("rst_ferr_odd",   8'(frame_err_odd), 8'h00);
        chk("rst_done_odd",   8'(rx_done_odd),   8'h00);
        rst_chk_done = rst_chk_req;
      end
      if (reset && rx_done_tick) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_strobe: got dout 0x%0h expected no strobe", dout);
        end else begin
          e = exp_q.pop_front();
          chk("dout",       dout,            e.d);
          chk("parity_err", 8'(parity_err),  8'(e.perr));
          chk("frame_err",  8'(frame_err),   8'(e.ferr));
        end
      end
      if (reset && rx_done_odd) begin
        if (exp_odd_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_strobe_odd: got dout 0x%0h expected no strobe", dout_odd);
        end else begin
          e = exp_odd_q.pop_front();
          chk("dout_odd",       dout_odd,            e.d);
          chk("parity_err_odd", 8'(parity_err_odd),  8'(e.perr));
          chk("frame_err_odd",  8'(frame_err_odd),   8'(e.ferr));
        end
      end
      if (end_req || cyc > CYC_LIMIT) begin
        if (!end_req) begin
          n_cmp++; n_bad++;
          $display("FAIL timeout: got %0d cycles expected at most %0d", cyc, CYC_LIMIT);
        end
        chk("pending_even", 8'(exp_q.size()),     8'h00);
        chk("pending_odd",  8'(exp_odd_q.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    end
  end

  // Stimulus
  initial begin
    reset = 1'b0;
    rx    = 1'b1;
    rst_chk_req = 1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    ticks(4);

    // Clean word, even parity satisfied
    expect_word(8'hE5, 1'b0, 1'b0);
    send_frame(8'hE5, 1'b1, 1'b1, -1, -1);

    // Wrong even parity (odd receiver accepts it)
    expect_word(8'h95, 1'b1, 1'b0);
    send_frame(8'h95, 1'b1, 1'b1, -1, -1);

    // Stop bit low, line held low: one strobe, then HOLD until line returns high
    expect_word(8'hCE, 1'b0, 1'b1);
    send_frame(8'hCE, 1'b1, 1'b0, -1, -1);
    ticks(48);
    rx = 1'b1;
    ticks(16);
    expect_word(8'h56, 1'b0, 1'b0);
    send_frame(8'h56, 1'b0, 1'b1, -1, -1);

    // Short low pulse rejected as a false start
    next_tick();
    rx = 1'b0;
    ticks(4);
    rx = 1'b1;
    ticks(16);
    expect_word(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b1, -1, -1);

    // Reset in the middle of bit 4; partial word dropped
    send_frame(8'hAA, 1'b0, 1'b1, -1, 4);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    ticks(8);
    expect_word(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, -1, -1);

    // One-tick glitch on bit 3 at its sample point
`ifdef UART_RX_MAJORITY_EN
    expect_word(8'h00, 1'b0, 1'b0);
`else
    expect_word(8'h08, 1'b1, 1'b0);
`endif
    send_frame(8'h00, 1'b0, 1'b1, 3, -1);

    ticks(20);
    end_req = 1'b1;
  end

endmodule
